// File: rtl/decode_stage_pipe.sv
// Registered RV32 decode stage: splits fields, builds immediates and branch/jump targets,
// and buffers one extra entry in a skid register so in_ready comes straight from a flop.
module decode_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [11:0]      csr,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  target,
    output logic [2:0]       inst_type,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] TYPE_R   = 3'b000;
    localparam logic [2:0] TYPE_I   = 3'b001;
    localparam logic [2:0] TYPE_U   = 3'b010;
    localparam logic [2:0] TYPE_CSR = 3'b011;
    localparam logic [2:0] TYPE_B   = 3'b100;
    localparam logic [2:0] TYPE_S   = 3'b101;
    localparam logic [2:0] TYPE_J   = 3'b110;
    localparam logic [2:0] TYPE_ILL = 3'b111;

    // One buffered instruction, carried with its decode results so both slots are interchangeable.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [2:0]      typ;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t            r_main;
    entry_t            r_skid;
    logic              r_out_valid;
    logic              r_skid_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic [2:0]        w_type;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic [XLEN-1:0]   w_target;
    entry_t            w_new;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_free;

    always_comb begin
        w_type = TYPE_ILL;
        case (in_inst[6:0])
            7'b0110011:                         w_type = TYPE_R;
            7'b0010011, 7'b0000011, 7'b1100111: w_type = TYPE_I;
            7'b0110111, 7'b0010111:             w_type = TYPE_U;
            7'b1110011:                         w_type = TYPE_CSR;
            7'b1100011:                         w_type = TYPE_B;
            7'b0100011:                         w_type = TYPE_S;
            7'b1101111:                         w_type = TYPE_J;
            default:                            w_type = TYPE_ILL;
        endcase
    end

    // Immediates are built as signed 32-bit values, then sign-extended to XLEN by the cast.
    always_comb begin
        w_imm32 = '0;
        case (w_type)
            TYPE_I: w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            TYPE_S: w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            TYPE_B: w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                               in_inst[11:8], 1'b0};
            TYPE_U: w_imm32 = {in_inst[31:12], 12'b0};
            TYPE_J: w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                               in_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm    = XLEN'(w_imm32);
    assign w_target = (w_type == TYPE_B || w_type == TYPE_J) ? (in_pc + w_imm) : '0;

    assign w_new.pc     = in_pc;
    assign w_new.inst   = in_inst;
    assign w_new.typ    = w_type;
    assign w_new.imm    = w_imm;
    assign w_new.target = w_target;

    assign w_in_fire   = in_valid & ~r_skid_valid;
    assign w_out_fire  = r_out_valid & out_ready;
    assign w_main_free = ~r_out_valid | out_ready;

    // Skid is only ever filled while main is stalled, and drains into main before new input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main      <= w_new;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_out_fire && (r_main.typ == TYPE_ILL) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready    = ~r_skid_valid;
    assign out_valid   = r_out_valid;
    assign out_pc      = r_main.pc;
    assign opcode      = r_main.inst[6:0];
    assign funct3      = r_main.inst[14:12];
    assign funct7      = r_main.inst[31:25];
    assign rs1         = r_main.inst[19:15];
    assign rs2         = r_main.inst[24:20];
    assign rd          = r_main.inst[11:7];
    assign csr         = r_main.inst[31:20];
    assign imm         = r_main.imm;
    assign target      = r_main.target;
    assign inst_type   = r_main.typ;
    assign illegal     = (r_main.typ == TYPE_ILL);
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: a reference decoder builds expectations when an
// instruction is accepted; they are popped and compared when the stage hands it downstream.
module tb_decode_stage_pipe;

    localparam int XLEN  = 32;
    localparam int EXP_W = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, illegal;
    logic [31:0] out_pc, imm, target;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3, inst_type;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr;
    logic [15:0] illegal_cnt;

    logic        d2_in_ready, d2_out_valid, d2_illegal;
    logic [31:0] d2_out_pc, d2_imm, d2_target;
    logic [6:0]  d2_opcode, d2_funct7;
    logic [2:0]  d2_funct3, d2_inst_type;
    logic [4:0]  d2_rs1, d2_rs2, d2_rd;
    logic [11:0] d2_csr;
    logic [1:0]  d2_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;
    logic rand_rdy = 1'b0;

    decode_stage_pipe #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1),
        .rs2(rs2), .rd(rd), .csr(csr), .imm(imm), .target(target), .inst_type(inst_type),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    decode_stage_pipe #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_pc(d2_out_pc), .opcode(d2_opcode), .funct3(d2_funct3), .funct7(d2_funct7),
        .rs1(d2_rs1), .rs2(d2_rs2), .rd(d2_rd), .csr(d2_csr), .imm(d2_imm),
        .target(d2_target), .inst_type(d2_inst_type), .illegal(d2_illegal),
        .illegal_cnt(d2_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] m_type(input logic [31:0] inst);
        case (inst[6:0])
            7'b0110011: return 3'd0;
            7'b0010011: return 3'd1;
            7'b0000011: return 3'd1;
            7'b1100111: return 3'd1;
            7'b0110111: return 3'd2;
            7'b0010111: return 3'd2;
            7'b1110011: return 3'd3;
            7'b1100011: return 3'd4;
            7'b0100011: return 3'd5;
            7'b1101111: return 3'd6;
            default:    return 3'd7;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] inst);
        logic [31:0] v;
        v = '0;
        case (m_type(inst))
            3'd1: v = {{20{inst[31]}}, inst[31:20]};
            3'd5: v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'd4: v = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            3'd2: v = {inst[31:12], 12'h000};
            3'd6: v = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

    // driver: hold the instruction until the stage accepts it
    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        int t;
        t = 0;
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
        else exp_q.push_back({pc, inst});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", exp_q.size(), 32'd0);
    endtask

    // scoreboard: compare every output transfer against the oldest expectation
    initial begin
        logic [EXP_W-1:0] e;
        logic [31:0] ei, ep, eimm;
        logic [2:0]  et;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    e    = exp_q.pop_front();
                    ep   = e[63:32];
                    ei   = e[31:0];
                    et   = m_type(ei);
                    eimm = m_imm(ei);
                    check("out_pc", out_pc, ep);
                    check("opcode", {25'b0, opcode}, {25'b0, ei[6:0]});
                    check("funct3", {29'b0, funct3}, {29'b0, ei[14:12]});
                    check("funct7", {25'b0, funct7}, {25'b0, ei[31:25]});
                    check("rs1", {27'b0, rs1}, {27'b0, ei[19:15]});
                    check("rs2", {27'b0, rs2}, {27'b0, ei[24:20]});
                    check("rd", {27'b0, rd}, {27'b0, ei[11:7]});
                    check("csr", {20'b0, csr}, {20'b0, ei[31:20]});
                    check("inst_type", {29'b0, inst_type}, {29'b0, et});
                    check("imm", imm, eimm);
                    check("target", target, (et == 3'd4 || et == 3'd6) ? ep + eimm : 32'd0);
                    check("illegal", {31'b0, illegal}, {31'b0, (et == 3'd7)});
                    if (et == 3'd7) model_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [6:0]  ops [11];
        logic [31:0] r;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111,
                7'b1110011, 7'b1100011, 7'b0100011, 7'b1101111, 7'b0000000};

        // reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_cnt", {16'b0, illegal_cnt}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_imm", imm, 32'd0);
        check("rst_target", target, 32'd0);
        check("rst_type", {29'b0, inst_type}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // basic I-type, one-cycle latency
        out_ready = 1'b1;
        send(32'h00A00093, 32'h100);
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_type", {29'b0, inst_type}, 32'd1);
        check("t1_rd", {27'b0, rd}, 32'd1);
        check("t1_imm", imm, 32'h0000000A);

        // branch and jump targets
        send(32'hFE000EE3, 32'h200);
        check("t2_beq_type", {29'b0, inst_type}, 32'd4);
        check("t2_beq_imm", imm, 32'hFFFFFFFC);
        check("t2_beq_target", target, 32'h000001FC);
        send(32'h0080006F, 32'h300);
        check("t2_jal_type", {29'b0, inst_type}, 32'd6);
        check("t2_jal_imm", imm, 32'h00000008);
        check("t2_jal_target", target, 32'h00000308);
        // target wraps modulo 2^32
        send(32'h0080006F, 32'hFFFFFFFC);
        check("t2_wrap_target", target, 32'h00000004);
        wait_drain();

        // backpressure fills skid, then drains in order
        out_ready = 1'b0;
        send(32'h00500113, 32'h400);
        send(32'h00208233, 32'h404);
        check("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("t3_hold_pc", out_pc, 32'h400);
        idle(2);
        check("t3_still_pc", out_pc, 32'h400);
        check("t3_still_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_drain();
        check("t3_in_ready_back", {31'b0, in_ready}, 32'd1);

        // flush with both slots full and a new input offered
        out_ready = 1'b0;
        send(32'h00000000, 32'h500);
        send(32'h00100093, 32'h504);
        in_inst  = 32'h00200113;
        in_pc    = 32'h508;
        in_valid = 1'b1;
        flush    = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        check("t4_out_valid", {31'b0, out_valid}, 32'd0);
        check("t4_in_ready", {31'b0, in_ready}, 32'd1);
        // flush with an input actually accepted in the same cycle
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_discard", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        idle(4);
        check("t4_cnt", {16'b0, illegal_cnt}, 32'd0);

        // illegal counter and saturation of the narrow instance
        send(32'h00000000, 32'h600);
        wait_drain();
        check("t5_cnt_one", {16'b0, illegal_cnt}, 32'd1);
        for (int i = 0; i < 5; i++) send(32'hFFFFFFFF, 32'h604 + 32'(i * 4));
        wait_drain();
        check("t5_cnt_six", {16'b0, illegal_cnt}, 32'd6);
        check("t5_cnt_sat", {30'b0, d2_cnt}, 32'd3);

        // random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            send({r[31:7], ops[$urandom_range(0, 10)]}, $urandom());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("rand_cnt", {16'b0, illegal_cnt}, 32'(model_cnt));
        check("rand_cnt_sat", {30'b0, d2_cnt}, (model_cnt > 3) ? 32'd3 : 32'(model_cnt));

        // asynchronous reset while full
        out_ready = 1'b0;
        send(32'h00000000, 32'h700);
        send(32'h00300193, 32'h704);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_in_ready", {31'b0, in_ready}, 32'd1);
        check("t6_cnt", {16'b0, illegal_cnt}, 32'd0);
        check("t6_cnt_sat", {30'b0, d2_cnt}, 32'd0);
        check("t6_out_pc", out_pc, 32'd0);
        check("t6_imm", imm, 32'd0);
        exp_q.delete();
        model_cnt = 0;
        #2;
        rst = 1'b0;
        idle(1);
        out_ready = 1'b1;
        send(32'h00C00293, 32'h800);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
